// File: rtl/hwpe_stream_tcdm_fetcher.sv
// Credit-based TCDM read master: steps the address generator, issues reads, streams in-order responses.
// Grant at t -> stream_valid_o at t+2; outstanding + buffered words never exceed DEPTH, so stream back-pressure throttles requests.
module hwpe_stream_tcdm_fetcher #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = DATA_WIDTH / 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [15:0]           trans_size_i,
  output logic                  addr_enable_o,
  input  logic [31:0]           gen_addr_i,
  input  logic [STEP-1:0]       gen_strb_i,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [31:0]           tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [STEP-1:0]       tcdm_be_o,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic [STEP-1:0]       stream_strb_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_size, r_req_cnt, r_pop_cnt;
  logic [CW-1:0]         r_outstanding, r_fifo_cnt;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr, r_sw_ptr, r_sr_ptr;
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [STEP-1:0]       r_strb_mem [DEPTH];
  logic [STEP-1:0]       r_side_mem [DEPTH];

  logic w_start, w_active, w_credit, w_req, w_grant, w_push, w_pop;

  assign w_start  = (r_state == IDLE) && start_i;
  assign w_active = (r_state == FETCH) || (r_state == DRAIN);
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < CW1'(DEPTH);
  assign w_req    = (r_state == FETCH) && (r_req_cnt < r_size) && w_credit;
  assign w_grant  = w_req && tcdm_gnt_i;
  // Responses arriving outside a transfer, or with nothing outstanding, are stale.
  assign w_push   = tcdm_r_valid_i && w_active && (r_outstanding != '0);
  assign w_pop    = stream_valid_o && stream_ready_i;

  assign tcdm_req_o     = w_req;
  assign addr_enable_o  = w_grant;
  assign tcdm_add_o     = gen_addr_i;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign stream_valid_o = (r_fifo_cnt != '0);
  assign stream_data_o  = r_data_mem[r_rd_ptr];
  assign stream_strb_o  = r_strb_mem[r_rd_ptr];
  assign busy_o         = (r_state != IDLE);
  assign done_o         = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = (trans_size_i == 16'd0) ? DONE : FETCH;
      FETCH:   if (w_grant && (r_req_cnt + 16'd1 == r_size)) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && (r_pop_cnt + 16'd1 == r_size)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state       <= IDLE;
      r_size        <= '0;
      r_req_cnt     <= '0;
      r_pop_cnt     <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_sw_ptr      <= '0;
      r_sr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data_mem[i] <= '0;
        r_strb_mem[i] <= '0;
        r_side_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_size        <= trans_size_i;
        r_req_cnt     <= '0;
        r_pop_cnt     <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_grant) r_req_cnt <= r_req_cnt + 16'd1;
        if (w_pop)   r_pop_cnt <= r_pop_cnt + 16'd1;
        r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_push);
      end
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      // Strobe is captured at grant and re-joined with its data word on response.
      if (w_grant) begin
        r_side_mem[r_sw_ptr] <= gen_strb_i;
        r_sw_ptr             <= r_sw_ptr + AW'(1);
      end
      if (w_push) begin
        r_data_mem[r_wr_ptr] <= tcdm_r_data_i;
        r_strb_mem[r_wr_ptr] <= r_side_mem[r_sr_ptr];
        r_wr_ptr             <= r_wr_ptr + AW'(1);
        r_sr_ptr             <= r_sr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetcher.sv
// Bench: generator/memory models around the fetcher, expected word stream built from transfer parameters.
module tb_hwpe_stream_tcdm_fetcher;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, start_i;
  logic [15:0] trans_size_i;
  logic        addr_enable_o;
  logic [31:0] gen_addr_i;
  logic [3:0]  gen_strb_i;
  logic        tcdm_req_o, tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic        tcdm_r_valid_i;
  logic [31:0] tcdm_r_data_i;
  logic        stream_valid_o, stream_ready_i;
  logic [31:0] stream_data_o;
  logic [3:0]  stream_strb_o;
  logic        busy_o, done_o;

  hwpe_stream_tcdm_fetcher #(.DATA_WIDTH(32), .STEP(4), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .trans_size_i(trans_size_i), .addr_enable_o(addr_enable_o),
    .gen_addr_i(gen_addr_i), .gen_strb_i(gen_strb_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int size;
    int gnt_pct;
    int rdy_pct;
    int exp_done;   // cycle of done_o after start in cycle 0, -1 when timing is random
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  int          gnt_pct, rdy_pct;
  logic [3:0]  strb_pat [3];
  logic [31:0] base;
  int          idx;
  logic        pend;
  logic [31:0] pend_dat;
  logic        stall_prev;
  logic [31:0] stall_addr;
  int          n_grant, n_beat, n_done, n_req, n_aen, cyc, done_cyc;
  logic [31:0] exp_dat_q [$];
  logic [3:0]  exp_strb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a;
  endfunction

  // One clock cycle: drive inputs at posedge+1, observe at posedge+2, advance to next posedge+1.
  task automatic cycle();
    logic aen;
    tcdm_r_valid_i = pend;
    tcdm_r_data_i  = pend ? pend_dat : 32'h0;
    gen_addr_i     = base + 32'(idx) * 32'd4;
    gen_strb_i     = strb_pat[idx % 3];
    tcdm_gnt_i     = ($urandom_range(0, 99) < gnt_pct);
    stream_ready_i = ($urandom_range(0, 99) < rdy_pct);
    #1;
    aen = addr_enable_o;
    if (tcdm_req_o) begin
      n_req++;
      check("tcdm_add", tcdm_add_o, base + 32'(idx) * 32'd4);
      if (stall_prev) check("addr_stable", tcdm_add_o, stall_addr);
    end
    if (!tcdm_gnt_i) check("aen_without_gnt", {31'b0, aen}, 32'h0);
    if (aen) n_aen++;
    pend = 1'b0;
    if (tcdm_req_o && tcdm_gnt_i) begin
      n_grant++;
      pend     = 1'b1;
      pend_dat = mem_rd(tcdm_add_o);
    end
    if (stream_valid_o && stream_ready_i) begin
      n_beat++;
      if (exp_dat_q.size() == 0) begin
        fail_now("extra_beat");
      end else begin
        check("beat_data", stream_data_o, exp_dat_q.pop_front());
        check("beat_strb", {28'b0, stream_strb_o}, {28'b0, exp_strb_q.pop_front()});
      end
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    stall_prev = tcdm_req_o && !tcdm_gnt_i;
    stall_addr = tcdm_add_o;
    @(posedge clk_i);
    #1;
    if (aen) idx++;
    cyc++;
  endtask

  task automatic start_xfer(input int size, input logic [31:0] b);
    base = b;
    idx  = 0;
    exp_dat_q.delete();
    exp_strb_q.delete();
    for (int i = 0; i < size; i++) begin
      exp_dat_q.push_back(mem_rd(b + 32'(i) * 32'd4));
      exp_strb_q.push_back(strb_pat[i % 3]);
    end
    n_grant = 0; n_beat = 0; n_done = 0; n_req = 0; n_aen = 0;
    cyc = 0; done_cyc = -1; stall_prev = 1'b0;
    start_i      = 1'b1;
    trans_size_i = 16'(size);
    cycle();
    start_i      = 1'b0;
    trans_size_i = 16'h0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n_done == 0 && n < budget) begin
      cycle();
      n++;
    end
    if (n_done == 0) fail_now("timeout_waiting_done");
  endtask

  task automatic finish_xfer(input int size, input int exp_done);
    check("busy_after_done", {31'b0, busy_o}, 32'h0);
    cycle();
    check("beats", 32'(n_beat), 32'(size));
    check("grants", 32'(n_grant), 32'(size));
    check("addr_enables", 32'(n_aen), 32'(size));
    check("done_pulses", 32'(n_done), 32'h1);
    check("words_left", 32'(exp_dat_q.size()), 32'h0);
    if (exp_done >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
  endtask

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    strb_pat[0] = 4'b1100;
    strb_pat[1] = 4'b1111;
    strb_pat[2] = 4'b0011;
    vecs[0] = '{size: 1,  gnt_pct: 100, rdy_pct: 100, exp_done: 4};
    vecs[1] = '{size: 8,  gnt_pct: 100, rdy_pct: 100, exp_done: 11};
    vecs[2] = '{size: 6,  gnt_pct: 50,  rdy_pct: 100, exp_done: -1};
    vecs[3] = '{size: 3,  gnt_pct: 100, rdy_pct: 100, exp_done: 6};
    vecs[4] = '{size: 5,  gnt_pct: 100, rdy_pct: 40,  exp_done: -1};
    vecs[5] = '{size: 12, gnt_pct: 70,  rdy_pct: 70,  exp_done: -1};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; trans_size_i = 16'h0;
    gen_addr_i = 32'h0; gen_strb_i = 4'h0; tcdm_gnt_i = 1'b0;
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = 32'h0; stream_ready_i = 1'b0;
    pend = 1'b0; pend_dat = 32'h0; base = 32'h0; idx = 0;
    gnt_pct = 100; rdy_pct = 100;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", {31'b0, tcdm_req_o}, 32'h0);
    check("rst_aen", {31'b0, addr_enable_o}, 32'h0);
    check("rst_valid", {31'b0, stream_valid_o}, 32'h0);
    check("rst_data", stream_data_o, 32'h0);
    check("rst_strb", {28'b0, stream_strb_o}, 32'h0);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_done", {31'b0, done_o}, 32'h0);
    check("rst_wen", {31'b0, tcdm_wen_o}, 32'h1);
    check("rst_be", {28'b0, tcdm_be_o}, 32'hF);
    rst_i = 1'b0;
    repeat (2) cycle();

    for (int i = 0; i < 6; i++) begin
      gnt_pct = vecs[i].gnt_pct;
      rdy_pct = vecs[i].rdy_pct;
      start_xfer(vecs[i].size, 32'h1000 + 32'(i) * 32'h100);
      wait_done(400);
      finish_xfer(vecs[i].size, vecs[i].exp_done);
    end

    // Zero-size transfer: no requests, short done pulse.
    gnt_pct = 100; rdy_pct = 100;
    start_xfer(0, 32'h2000);
    wait_done(5);
    check("zero_done_window", {31'b0, (done_cyc >= 1 && done_cyc <= 2)}, 32'h1);
    finish_xfer(0, -1);
    check("zero_no_req", 32'(n_req), 32'h0);

    // Back-pressure: credits stop requests at DEPTH words.
    gnt_pct = 100; rdy_pct = 0;
    start_xfer(16, 32'h3000);
    repeat (20) cycle();
    check("bp_grants", 32'(n_grant), 32'(DEPTH));
    check("bp_req_low", {31'b0, tcdm_req_o}, 32'h0);
    check("bp_no_beats", 32'(n_beat), 32'h0);
    rdy_pct = 100;
    wait_done(200);
    finish_xfer(16, -1);

    // Clear with a response in flight, then restart.
    gnt_pct = 100; rdy_pct = 0;
    start_xfer(10, 32'h4000);
    begin
      int n;
      n = 0;
      while (n_grant < 3 && n < 20) begin
        cycle();
        n++;
      end
      if (n_grant < 3) fail_now("clear_setup_grants");
    end
    check("clear_resp_pending", {31'b0, pend}, 32'h1);
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    check("clear_busy", {31'b0, busy_o}, 32'h0);
    check("clear_valid", {31'b0, stream_valid_o}, 32'h0);
    check("clear_no_done", 32'(n_done), 32'h0);
    check("clear_stale_pending", {31'b0, pend}, 32'h1);
    rdy_pct = 100;
    start_xfer(2, 32'h5000);
    wait_done(50);
    finish_xfer(2, 5);

    // Randomised transfers against the expected-stream model.
    for (int r = 0; r < 10; r++) begin
      gnt_pct = $urandom_range(30, 100);
      rdy_pct = $urandom_range(30, 100);
      start_xfer($urandom_range(1, 20), {$urandom} & 32'hFFFF_FFF0);
      wait_done(2000);
      finish_xfer(exp_dat_q.size() + n_beat, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
